p_nand_acc: RTL and testbench

P_NAND_ACC -- requirements
Module: p_nand_acc

---
 rtl/p_nand_pkg.sv | 15 +
 rtl/p_nand.sv | 20 ++
 rtl/p_nand_acc.sv | 90 +++++++++
 tb/tb_p_nand_acc.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/p_nand_pkg.sv
// Shared types and helpers for the NAND accumulator: FSM state encoding and
// operand-counter width.
package p_nand_pkg;

  typedef enum logic {
    StCollect,
    StHold
  } state_e;

  // Counter width that can hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n <= 32'd2) ? 32'd1 : $unsigned($clog2(n));
  endfunction

endpackage

// File: rtl/p_nand.sv
// Combinational bitwise NAND across NB_INS packed operands of BUS_WIDTH bits.
module p_nand #(
  parameter int unsigned BUS_WIDTH = 4,
  parameter int unsigned NB_INS    = 2
) (
  input  logic [NB_INS*BUS_WIDTH-1:0] in_bus,
  output logic [BUS_WIDTH-1:0]        out_bus
);

  logic [BUS_WIDTH-1:0] and_v;

  always_comb begin
    and_v = '1;
    for (int unsigned i = 0; i < NB_INS; i++) begin
      and_v = and_v & in_bus[i*BUS_WIDTH +: BUS_WIDTH];
    end
    out_bus = ~and_v;
  end

endmodule

// File: rtl/p_nand_acc.sv
// Streaming accumulator: collects NB_INS operands over a valid/ready link and
// presents their bitwise NAND as one held result.
module p_nand_acc
  import p_nand_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 4,
  parameter int unsigned NB_INS    = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [BUS_WIDTH-1:0]             in_bus,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [BUS_WIDTH-1:0]             out_bus,
  output logic [cnt_width(NB_INS)-1:0]     op_count
);

  localparam int unsigned CntW = cnt_width(NB_INS);
  localparam logic [CntW-1:0] LastCnt = CntW'(NB_INS - 1);

  state_e               state_q, state_d;
  logic [BUS_WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] result_q, result_d;
  logic [BUS_WIDTH-1:0] nand_out;

  // Final result folds the running AND with the last operand in one step.
  p_nand #(
    .BUS_WIDTH (BUS_WIDTH),
    .NB_INS    (2)
  ) u_p_nand (
    .in_bus  ({acc_q, in_bus}),
    .out_bus (nand_out)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      StCollect: begin
        if (clear) begin
          acc_d = '1;
          cnt_d = '0;
        end else if (in_valid) begin
          if (cnt_q == LastCnt) begin
            result_d = nand_out;
            acc_d    = '1;
            cnt_d    = '0;
            state_d  = StHold;
          end else begin
            acc_d = acc_q & in_bus;
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StHold: begin
        // clear and a consumer handshake both drop the result
        if (clear || out_ready) begin
          result_d = '0;
          state_d  = StCollect;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StCollect;
      acc_q    <= '1;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == StCollect);
  assign out_valid = (state_q == StHold);
  assign out_bus   = out_valid ? result_q : '0;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_p_nand_acc.sv
// Self-checking bench for p_nand_acc: vector table, directed corner cases and
// a randomized stall run against a queue-based reference model.
module tb_p_nand_acc;

  localparam int unsigned NB = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_bus;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_bus;
  logic [1:0] op_count;

  logic       clear2;
  logic       in_valid2;
  logic       in_ready2;
  logic [7:0] in_bus2;
  logic       out_valid2;
  logic       out_ready2;
  logic [7:0] out_bus2;
  logic [0:0] op_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  p_nand_acc dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bus    (in_bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bus   (out_bus),
    .op_count  (op_count)
  );

  p_nand_acc #(
    .BUS_WIDTH (8),
    .NB_INS    (1)
  ) dut1 (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear2),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .in_bus    (in_bus2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .out_bus   (out_bus2),
    .op_count  (op_count2)
  );

  typedef struct {
    logic       vld;
    logic [3:0] din;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [3:0] e_ob;
    logic [1:0] e_cnt;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d);
    in_valid = 1'b1;
    in_bus   = d;
    tick();
  endtask

  // Reference model state for the random run
  logic [3:0] ops[$];
  logic [3:0] exp_res;
  logic [3:0] r;
  bit         pending;
  int         produced;
  int         delivered;
  int         dut_hs;
  logic       rv;
  logic       ro;
  logic [3:0] rd;

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_bus = '0; out_ready = 1'b0;
    clear2 = 1'b0; in_valid2 = 1'b0; in_bus2 = '0; out_ready2 = 1'b0;

    // Back-to-back operation: 1101 & 1011 & 1111 = 1001 -> NAND 0110
    vecs[0] = '{vld: 1'b1, din: 4'b1101, ordy: 1'b1, e_ir: 1'b1, e_ov: 1'b0, e_ob: 4'h0, e_cnt: 2'd0};
    vecs[1] = '{vld: 1'b1, din: 4'b1011, ordy: 1'b1, e_ir: 1'b1, e_ov: 1'b0, e_ob: 4'h0, e_cnt: 2'd1};
    vecs[2] = '{vld: 1'b1, din: 4'b1111, ordy: 1'b1, e_ir: 1'b1, e_ov: 1'b0, e_ob: 4'h0, e_cnt: 2'd2};
    vecs[3] = '{vld: 1'b0, din: 4'b0000, ordy: 1'b1, e_ir: 1'b0, e_ov: 1'b1, e_ob: 4'b0110, e_cnt: 2'd0};
    vecs[4] = '{vld: 1'b0, din: 4'b0000, ordy: 1'b1, e_ir: 1'b1, e_ov: 1'b0, e_ob: 4'h0, e_cnt: 2'd0};

    repeat (3) tick();
    rst = 1'b0;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_bus", out_bus, 4'h0);
    check("reset_op_count", op_count, 2'd0);

    for (int i = 0; i < 5; i++) begin
      check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_ir);
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
      check($sformatf("vec%0d_out_bus", i), out_bus, vecs[i].e_ob);
      check($sformatf("vec%0d_op_count", i), op_count, vecs[i].e_cnt);
      in_valid  = vecs[i].vld;
      in_bus    = vecs[i].din;
      out_ready = vecs[i].ordy;
      tick();
    end

    // Stall in HOLD with in_valid held high
    out_ready = 1'b0;
    send(4'b1101); send(4'b1011); send(4'b1111);
    in_bus = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_out_bus", out_bus, 4'b0110);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_op_count", op_count, 2'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("release_in_ready", in_ready, 1'b1);
    check("release_op_count", op_count, 2'd0);
    send(4'b0000); send(4'b1111); send(4'b1111);
    in_valid = 1'b0;
    check("post_stall_out_bus", out_bus, 4'b1111);
    tick();

    // Clear aborts a partial operation and drops the simultaneous operand
    send(4'b1101); send(4'b1011);
    check("pre_clear_op_count", op_count, 2'd2);
    clear = 1'b1; in_valid = 1'b1; in_bus = 4'b0101;
    tick();
    clear = 1'b0;
    check("clear_op_count", op_count, 2'd0);
    check("clear_in_ready", in_ready, 1'b1);
    send(4'b0000); send(4'b1111); send(4'b1111);
    in_valid = 1'b0;
    check("clear_out_valid", out_valid, 1'b1);
    check("clear_out_bus", out_bus, 4'b1111);
    tick();

    // Clear in HOLD discards the result
    send(4'b1101); send(4'b1011); send(4'b1111);
    in_valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("hold_clear_out_valid", out_valid, 1'b0);
    check("hold_clear_out_bus", out_bus, 4'h0);

    // Asynchronous reset in HOLD
    out_ready = 1'b0;
    send(4'b1101); send(4'b1011); send(4'b1111);
    in_valid = 1'b0;
    check("prerst_out_bus", out_bus, 4'b0110);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_out_bus", out_bus, 4'h0);
    check("async_rst_op_count", op_count, 2'd0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    send(4'b1101);
    in_valid = 1'b0;
    check("first_accept_op_count", op_count, 2'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // NB_INS=1, 8-bit instance
    check("nb1_in_ready", in_ready2, 1'b1);
    in_valid2 = 1'b1; in_bus2 = 8'hA5;
    tick();
    in_valid2 = 1'b0;
    check("nb1_out_valid", out_valid2, 1'b1);
    check("nb1_out_bus", out_bus2, 8'h5A);
    out_ready2 = 1'b1;
    tick();
    check("nb1_done_out_valid", out_valid2, 1'b0);
    check("nb1_done_out_bus", out_bus2, 8'h00);

    // Random stall run against the reference model
    pending = 0; produced = 0; delivered = 0; dut_hs = 0; exp_res = '0;
    ops.delete();
    for (int c = 0; c < 600; c++) begin
      check("rnd_in_ready", in_ready, !pending);
      check("rnd_out_valid", out_valid, pending);
      check("rnd_out_bus", out_bus, pending ? exp_res : 4'h0);
      check("rnd_op_count", op_count, ops.size());
      rv = 1'($urandom_range(0, 1));
      ro = 1'($urandom_range(0, 1));
      rd = 4'($urandom);
      in_valid = rv; out_ready = ro; in_bus = rd;
      if (out_valid && ro) dut_hs++;
      if (pending) begin
        if (ro) begin
          pending = 0;
          delivered++;
        end
      end else if (rv) begin
        ops.push_back(rd);
        if (ops.size() == NB) begin
          r = 4'hF;
          foreach (ops[k]) r = r & ops[k];
          exp_res = ~r;
          pending = 1;
          produced++;
          ops.delete();
        end
      end
      tick();
    end
    check("rnd_handshake_count", dut_hs, delivered);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
